inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Packs decoded instruction fields plus a 32-bit immediate back into an RV32I instruction word.
- Inverse of the immediate decoder in the single-cycle core. Every format the decoder extracts is packed here, plus R-type.
- Used by the program loader / self-test path to build instruction memory images in hardware.
- Input side is a valid/ready handshake. Output side is a FIFO-buffered valid/ready stream that carries a memory byte address per word.

Parameters:
- DEPTH, 4: output FIFO entries; power of 2, minimum 2.
- ADDR_W, 32: width of the write-address counter.
- BASE_ADDR, 32'h00000000: first address emitted after reset; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept; equals !fifo_full.
- opcode  input  7  inst[6:0] value to encode.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field; R-type only.
- imm  input  32  full signed immediate, in the form the decoder would produce.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head entry.
- out_inst  output  32  encoded word at FIFO head.
- out_addr  output  ADDR_W  byte address bound to the head word.
- out_err  output  1  head word had a range or opcode error.
- err_sticky  output  1  set on any accepted erroneous request.
- err_clr  input  1  synchronous clear of err_sticky.
- word_count  output  16  number of accepted requests; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0) forces the following immediately, and they hold until the first clk edge with rst_n=1:
  - FIFO empty, so out_valid=0 and in_ready=1.
  - out_inst=0, out_err=0, out_addr=BASE_ADDR.
  - err_sticky=0, word_count=0.
  - Address counter = BASE_ADDR.
- Accept:
  - A push occurs when in_valid && in_ready at a rising edge.
  - On a push: the combinationally encoded word, its error flag and the current address counter are written to the FIFO tail.
  - Then the address counter += 4 (wraps mod 2^ADDR_W) and word_count += 1.
- Pop: occurs when out_valid && out_ready at a rising edge; the head advances.
- Latency: a word pushed at edge N is visible on out_* after edge N when the FIFO was empty. There is no combinational input-to-output path.
- Full FIFO:
  - in_ready=0, so no push even if a pop occurs in the same cycle (no pass-through).
  - in_ready rises the cycle after the pop.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and ordering is preserved.
- Encoding (X = sign-bits range check: imm[31:k] all equal):
  - 0010011, 0000011: {imm[11:0], rs1, funct3, rd, opcode}. Error if !X(k=11).
  - 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Error if !X(k=11).
  - 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Error if !X(k=12) or imm[0]=1.
  - 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Error if !X(k=20) or imm[0]=1.
  - 0110111, 0010111: {imm[31:12], rd, opcode}. Error if imm[11:0] != 0.
  - 0110011: {funct7, rs2, rs1, funct3, rd, opcode}; imm is ignored, never an error.
  - Any other opcode: word = 32'h00000013 (NOP), error = 1.
- Erroneous words are still emitted, truncated per the field map above, with out_err=1.
- err_sticky:
  - Set on the push of an erroneous request.
  - err_clr clears it at the next edge.
  - If a set and err_clr occur in the same cycle, set wins.
- Reset mid-stream discards all FIFO contents and restarts addressing at BASE_ADDR.
- Round-trip invariant: decoding out_inst with the core's immediate decoder returns the input imm for every non-error request.

Test Plan:
- Reset release, then push opcode=0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF:
  - out_inst=32'hFFF00093, out_addr=0, out_err=0, one cycle after accept.
- Branch push opcode=1100011, rs1=1, rs2=2, funct3=0, imm=32'hFFFFFFFC -> out_inst=32'hFE208EE3.
- JAL push rd=1, imm=32'h00000800 -> out_inst=32'h001000EF.
- Range errors:
  - ADDI with imm=32'h00000800 -> out_err=1 and err_sticky=1.
  - Then err_clr together with a LUI push with imm[11:0]=12'h001 -> err_sticky remains 1.
- Backpressure:
  - Hold out_ready=0 and push DEPTH+2 requests -> in_ready=0 after DEPTH accepts.
  - Release out_ready -> words drain in order at addresses 0, 4, 8, 12, then the remaining two are accepted.
- Reset mid-stream:
  - Assert rst_n=0 with 3 entries queued -> out_valid=0 immediately.
  - After release, the next word gets out_addr=BASE_ADDR and word_count restarts at 1.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction packer: turns decoded fields plus a full immediate back into an instruction
// word and queues it, with its byte address and an error flag, in a small output FIFO.
module inst_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [15:0]       word_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        ok11, ok12, ok20;

    // imm[31:k] must be pure sign extension for the immediate to fit its field
    assign ok11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign ok12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign ok20 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b1;
        case (opcode)
            7'b0010011, 7'b0000011: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = ~ok11;
            end
            7'b0100011: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = ~ok11;
            end
            7'b1100011: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = ~ok12 | imm[0];
            end
            7'b1101111: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = ~ok20 | imm[0];
            end
            7'b0110111, 7'b0010111: begin
                enc_word = {imm[31:12], rd, opcode};
                enc_err  = |imm[11:0];
            end
            7'b0110011: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_err  = 1'b0;
            end
            default: ;
        endcase
    end

    logic [31:0]       mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DEPTH-1:0]  mem_err;

    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wcount_q;
    logic              sticky_q;
    logic              full, push, pop;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign in_ready  = ~full;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wptr_q] <= enc_word;
            mem_addr[wptr_q] <= addr_q;
            mem_err[wptr_q]  <= enc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            wcount_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q   <= wptr_q + 1'b1;
                addr_q   <= addr_q + ADDR_W'(4);
                wcount_q <= wcount_q + 16'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push && enc_err) begin
                sticky_q <= 1'b1;
            end else if (err_clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign out_inst   = out_valid ? mem_inst[rptr_q] : '0;
    assign out_addr   = out_valid ? mem_addr[rptr_q] : addr_q;
    assign out_err    = out_valid & mem_err[rptr_q];
    assign err_sticky = sticky_q;
    assign word_count = wcount_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: fixed encoding vectors, handshake corner sequences and random traffic
// scored against an arithmetic encoder model, a FIFO queue and an immediate decoder.
module tb_inst_encoder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;
    logic        err_clr = 1'b0;
    logic [15:0] word_count;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_sticky(err_sticky), .err_clr(err_clr), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    exp_t        q[$];
    logic [31:0] addr_m;
    logic [15:0] wc_m;
    logic        sticky_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mkv(logic [6:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                 logic [2:0] f3, logic [6:0] f7, logic [31:0] im,
                                 logic [31:0] inst, logic err);
        vec_t v;
        v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7; v.imm = im;
        v.inst = inst; v.err = err;
        return v;
    endfunction

    // Encoder model: fields placed by shift-and-mask, fit checked as a signed numeric range.
    function automatic void ref_encode(input vec_t r, output logic [31:0] w, output logic e);
        int s;
        logic [31:0] regs;
        s = signed'(r.imm);
        regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
        case (r.op)
            7'h13, 7'h03: begin
                e = (s < -2048) || (s > 2047);
                w = ((r.imm & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
                    | (32'(r.rd) << 7) | 32'(r.op);
            end
            7'h23: begin
                e = (s < -2048) || (s > 2047);
                w = (((r.imm >> 5) & 32'h7F) << 25) | regs | ((r.imm & 32'h1F) << 7) | 32'(r.op);
            end
            7'h63: begin
                e = (s < -4096) || (s > 4095) || (r.imm % 2 != 0);
                w = (((r.imm >> 12) & 1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) | regs
                    | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 1) << 7) | 32'(r.op);
            end
            7'h6F: begin
                e = (s < -1048576) || (s > 1048575) || (r.imm % 2 != 0);
                w = (((r.imm >> 20) & 1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
                    | (((r.imm >> 11) & 1) << 20) | (((r.imm >> 12) & 32'hFF) << 12)
                    | (32'(r.rd) << 7) | 32'(r.op);
            end
            7'h37, 7'h17: begin
                e = (r.imm % 4096) != 0;
                w = (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.op);
            end
            7'h33: begin
                e = 1'b0;
                w = (32'(r.f7) << 25) | regs | (32'(r.rd) << 7) | 32'(r.op);
            end
            default: begin
                e = 1'b1;
                w = 32'h0000_0013;
            end
        endcase
    endfunction

    // Standard RV32I immediate decoder, used for the round-trip property.
    function automatic logic [31:0] dec_imm(input logic [6:0] op, input logic [31:0] w);
        logic [31:0] sgn;
        sgn = 32'($signed(w) >>> 31);
        case (op)
            7'h13, 7'h03: return 32'($signed(w) >>> 20);
            7'h23: return (sgn << 11) | (((w >> 25) & 32'h3F) << 5) | ((w >> 7) & 32'h1F);
            7'h63: return (sgn << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5)
                          | (((w >> 8) & 32'hF) << 1);
            7'h6F: return (sgn << 20) | (w & 32'h000FF000) | (((w >> 20) & 1) << 11)
                          | (((w >> 21) & 32'h3FF) << 1);
            default: return w & 32'hFFFFF000;
        endcase
    endfunction

    // Check outputs against the model, drive one cycle of inputs, clock, update the model.
    task automatic step(input logic v, input logic ordy, input logic clr, input vec_t r,
                        output logic pushed, output logic popped, output logic [31:0] pop_addr);
        logic [31:0] w;
        logic        e;
        exp_t        x;
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_addr", out_addr, q[0].addr);
            chk("out_err", out_err, q[0].err);
        end
        chk("err_sticky", err_sticky, sticky_m);
        chk("word_count", word_count, wc_m);
        pop_addr = out_addr;
        in_valid = v; out_ready = ordy; err_clr = clr;
        opcode = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; funct3 = r.f3; funct7 = r.f7;
        imm = r.imm;
        @(posedge clk);
        pushed = v && (q.size() < DEPTH);
        popped = ordy && (q.size() > 0);
        if (popped) begin
            x = q.pop_front();
            if (!x.err && x.op != 7'h33) chk("round_trip", dec_imm(x.op, x.inst), x.imm);
        end
        if (pushed) begin
            ref_encode(r, w, e);
            x.op = r.op; x.imm = r.imm; x.inst = w; x.addr = addr_m; x.err = e;
            q.push_back(x);
            addr_m = addr_m + 32'd4;
            wc_m = wc_m + 16'd1;
        end
        if (pushed && e) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        addr_m = 32'h0;
        wc_m = '0;
        sticky_m = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_word_count", word_count, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{19{r[12]}}, r[12:1], 1'b0};
            3: return {{11{r[20]}}, r[20:1], 1'b0};
            default: return {r[31:12], 12'h000};
        endcase
    endfunction

    vec_t        vecs[13];
    vec_t        idle;
    logic        pu, po;
    logic [31:0] pa;

    initial begin
        vecs[0]  = mkv(7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 0);
        vecs[1]  = mkv(7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 32'hFE208EE3, 0);
        vecs[2]  = mkv(7'h6F, 1, 0, 0, 0, 0, 32'h00000800, 32'h001000EF, 0);
        vecs[3]  = mkv(7'h13, 1, 0, 0, 0, 0, 32'h00000800, 32'h80000093, 1);
        vecs[4]  = mkv(7'h37, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0);
        vecs[5]  = mkv(7'h37, 0, 0, 0, 0, 0, 32'h00001001, 32'h00001037, 1);
        vecs[6]  = mkv(7'h23, 0, 2, 3, 2, 0, 32'h00000008, 32'h00312423, 0);
        vecs[7]  = mkv(7'h33, 3, 1, 2, 0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 0);
        vecs[8]  = mkv(7'h7F, 1, 2, 3, 1, 0, 32'h00000000, 32'h00000013, 1);
        vecs[9]  = mkv(7'h63, 0, 0, 0, 1, 0, 32'h00000005, 32'h00001263, 1);
        vecs[10] = mkv(7'h17, 10, 0, 0, 0, 0, 32'hFFFFF000, 32'hFFFFF517, 0);
        vecs[11] = mkv(7'h03, 4, 2, 0, 2, 0, 32'hFFFFF7FF, 32'h7FF12203, 1);
        vecs[12] = mkv(7'h6F, 0, 0, 0, 0, 0, 32'h00100000, 32'h8000006F, 1);
        idle = mkv(7'h13, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        model_clear();

        #2;
        do_reset();

        // Encoding table: each word appears one cycle after accept, then is popped.
        for (int i = 0; i < 13; i++) begin
            step(1, 0, 0, vecs[i], pu, po, pa);
            chk("vec_valid", out_valid, 1);
            chk("vec_inst", out_inst, vecs[i].inst);
            chk("vec_err", out_err, vecs[i].err);
            chk("vec_addr", out_addr, 32'(i) * 32'd4);
            step(0, 1, 0, idle, pu, po, pa);
        end

        // Sticky error: clear, set, then set racing a clear, then clear.
        step(0, 0, 1, idle, pu, po, pa);
        chk("sticky_cleared", err_sticky, 0);
        step(1, 0, 0, mkv(7'h13, 1, 0, 0, 0, 0, 32'h800, 0, 1), pu, po, pa);
        chk("sticky_set", err_sticky, 1);
        chk("sticky_head_err", out_err, 1);
        step(1, 1, 1, mkv(7'h37, 2, 0, 0, 0, 0, 32'h00001001, 0, 1), pu, po, pa);
        chk("sticky_set_wins", err_sticky, 1);
        step(0, 1, 1, idle, pu, po, pa);
        chk("sticky_clear", err_sticky, 0);

        // Backpressure: DEPTH+2 requests against a stalled consumer, then drain.
        do_reset();
        begin
            int acc, nxt, popn;
            acc = 0;
            for (int i = 0; i < DEPTH + 2; i++) begin
                step(1, 0, 0, mkv(7'h13, 5'(i), 0, 0, 0, 0, 32'(i), 0, 0), pu, po, pa);
                if (pu) acc++;
            end
            chk("bp_accepts", acc, DEPTH);
            chk("bp_full_in_ready", in_ready, 0);
            nxt = DEPTH;
            popn = 0;
            for (int c = 0; c < 12; c++) begin
                step(nxt < DEPTH + 2, 1, 0, mkv(7'h13, 5'(nxt), 0, 0, 0, 0, 32'(nxt), 0, 0),
                     pu, po, pa);
                if (po) begin
                    chk("drain_addr", pa, 32'(popn) * 32'd4);
                    popn++;
                end
                if (pu) nxt++;
            end
            chk("drain_count", popn, DEPTH + 2);
            chk("late_accepts", nxt, DEPTH + 2);
        end

        // Random traffic, alternating between a fast and a slow consumer.
        for (int c = 0; c < 600; c++) begin
            vec_t r;
            logic [6:0] ops[10];
            ops = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h33, 7'h00};
            r.op = ops[$urandom_range(0, 9)];
            if (r.op == 7'h00) r.op = 7'($urandom);
            r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
            r.f3 = 3'($urandom); r.f7 = 7'($urandom); r.imm = rand_imm();
            r.inst = '0; r.err = 1'b0;
            step($urandom_range(0, 3) != 0,
                 ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 15) == 0, r, pu, po, pa);
        end

        // Reset with three words queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, vecs[i], pu, po, pa);
        chk("mid_queued_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_count", word_count, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, vecs[4], pu, po, pa);
        chk("mid_after_addr", out_addr, 0);
        chk("mid_after_count", word_count, 1);
        chk("mid_after_inst", out_inst, 32'h123452B7);
        step(0, 1, 0, idle, pu, po, pa);
        step(0, 0, 0, idle, pu, po, pa);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
